// File: rtl/msxbus_arbiter_if.sv
// Requester, completion and engine-command signals of the MSX bus arbiter.
// The arbiter takes the master modport; requesters and the engine model take the slave modport.
interface msxbus_arbiter_if;
  logic        req0;
  logic        req1;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [7:0]  wdata0;
  logic [7:0]  wdata1;
  logic [2:0]  ctl0;
  logic [2:0]  ctl1;
  logic        done0;
  logic        done1;
  logic        tout;
  logic [7:0]  rdata;
  logic        busy;
  logic        en;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic        mio;
  logic        rw;
  logic        slot;
  logic        brst_n;
  logic [7:0]  erdata;
  logic        val;

  modport master (
    input  req0, req1, addr0, addr1, wdata0, wdata1, ctl0, ctl1, erdata, val,
    output done0, done1, tout, rdata, busy, en, address, wdata, mio, rw, slot, brst_n
  );

  modport slave (
    output req0, req1, addr0, addr1, wdata0, wdata1, ctl0, ctl1, erdata, val,
    input  done0, done1, tout, rdata, busy, en, address, wdata, mio, rw, slot, brst_n
  );
endinterface

// File: rtl/msxbus_arbiter.sv
// Round-robin arbiter that shares one MSX bus cycle engine between two requesters,
// runs its enable/done handshake, re-arms it after each cycle and aborts stuck cycles.
module msxbus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input logic              clk,
  input logic              rst,
  msxbus_arbiter_if.master bus
);

  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StGrant, StRun, StFinish} state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        gnt_q, gnt_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [2:0]  ctl_q, ctl_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        tout_q, tout_d;
  logic        pick;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ctl_d   = ctl_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    tout_d  = tout_q;
    pick    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester not served last wins.
          pick    = (bus.req0 && bus.req1) ? ~ptr_q : bus.req1;
          gnt_d   = pick;
          addr_d  = pick ? bus.addr1 : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          ctl_d   = pick ? bus.ctl1 : bus.ctl0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        cnt_d   = '0;
        state_d = StRun;
      end
      StRun: begin
        cnt_d = cnt_q + 16'd1;
        if (!bus.val) begin
          rdata_d = bus.erdata;
          tout_d  = 1'b0;
          state_d = StFinish;
        end else if (cnt_q == CntLast) begin
          rdata_d = 8'hFF;
          tout_d  = 1'b1;
          state_d = StFinish;
        end
      end
      StFinish: begin
        ptr_d   = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 1'b1;
      gnt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ctl_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ctl_q   <= ctl_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      tout_q  <= tout_d;
    end
  end

  // The engine is held in reset for the whole of our own reset, not just in FINISH.
  assign bus.brst_n  = ~rst & (state_q != StFinish);
  assign bus.en      = (state_q == StRun);
  assign bus.busy    = (state_q != StIdle);
  assign bus.done0   = (state_q == StFinish) & ~gnt_q;
  assign bus.done1   = (state_q == StFinish) & gnt_q;
  assign bus.tout    = tout_q;
  assign bus.rdata   = rdata_q;
  assign bus.address = addr_q;
  assign bus.wdata   = wdata_q;
  assign bus.mio     = ctl_q[2];
  assign bus.rw      = ctl_q[1];
  assign bus.slot    = ctl_q[0];

endmodule

// File: tb/tb_msxbus_arbiter.sv
// Directed bench for msxbus_arbiter with a short watchdog (8 cycles); the engine is
// modelled by driving VAL/ERDATA directly at hand-chosen cycles.
module tb_msxbus_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  msxbus_arbiter_if bus ();

  msxbus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int          g;
    logic [15:0] exp_addr;
    logic [2:0]  exp_ctl;
    logic [7:0]  exp_rd;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.addr0  = '0;
    bus.addr1  = '0;
    bus.wdata0 = '0;
    bus.wdata1 = '0;
    bus.ctl0   = '0;
    bus.ctl1   = '0;
    bus.erdata = '0;
    bus.val    = 1'b1;
    #1;
    chk("rst_en", bus.en, 0);
    chk("rst_brst_n", bus.brst_n, 0);
    chk("rst_address", bus.address, 0);
    chk("rst_ctl", {bus.mio, bus.rw, bus.slot}, 0);
    chk("rst_done", {bus.done0, bus.done1}, 0);
    chk("rst_tout", bus.tout, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_busy", bus.busy, 0);
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_brst_n", bus.brst_n, 1);

    // Single read: VAL drops on the third EN cycle.
    bus.req0   = 1'b1;
    bus.addr0  = 16'h4000;
    bus.ctl0   = 3'b000;
    bus.wdata0 = 8'h11;
    step();
    chk("rd_grant_busy", bus.busy, 1);
    chk("rd_grant_en", bus.en, 0);
    chk("rd_grant_addr", bus.address, 16'h4000);
    chk("rd_grant_wdata", bus.wdata, 8'h11);
    step();
    chk("rd_en1", bus.en, 1);
    bus.req0 = 1'b0;
    step();
    chk("rd_en2", bus.en, 1);
    step();
    chk("rd_en3", bus.en, 1);
    bus.val    = 1'b0;
    bus.erdata = 8'hA5;
    step();
    chk("rd_done0", bus.done0, 1);
    chk("rd_done1", bus.done1, 0);
    chk("rd_rdata", bus.rdata, 8'hA5);
    chk("rd_tout", bus.tout, 0);
    chk("rd_fin_en", bus.en, 0);
    chk("rd_fin_brst_n", bus.brst_n, 0);
    bus.val = 1'b1;
    step();
    chk("rd_idle_done", {bus.done0, bus.done1}, 0);
    chk("rd_idle_brst_n", bus.brst_n, 1);
    chk("rd_idle_busy", bus.busy, 0);
    chk("rd_hold_rdata", bus.rdata, 8'hA5);

    // Both requesters held: last grant was 0, so grants go 1,0,1,0.
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.addr0 = 16'h1000;
    bus.addr1 = 16'h2000;
    bus.ctl0  = 3'b101;
    bus.ctl1  = 3'b010;
    bus.val   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      g        = (i % 2 == 0) ? 1 : 0;
      exp_addr = (g == 1) ? 16'h2000 : 16'h1000;
      exp_ctl  = (g == 1) ? 3'b010 : 3'b101;
      exp_rd   = 8'h30 + 8'(i);
      bus.erdata = exp_rd;
      step();
      chk("rr_grant_addr", bus.address, exp_addr);
      chk("rr_grant_ctl", {bus.mio, bus.rw, bus.slot}, exp_ctl);
      step();
      chk("rr_run_en", bus.en, 1);
      step();
      chk("rr_done0", bus.done0, (g == 0) ? 1 : 0);
      chk("rr_done1", bus.done1, (g == 1) ? 1 : 0);
      chk("rr_rdata", bus.rdata, exp_rd);
      step();
      chk("rr_idle_done", {bus.done0, bus.done1}, 0);
      if (i == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end
    bus.val = 1'b1;

    // Timeout: VAL stuck high, EN lasts exactly 8 cycles.
    bus.req1  = 1'b1;
    bus.addr1 = 16'hBEEF;
    step();
    chk("to_grant_addr", bus.address, 16'hBEEF);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("to_en", bus.en, 1);
      bus.req1 = 1'b0;
    end
    step();
    chk("to_done1", bus.done1, 1);
    chk("to_done0", bus.done0, 0);
    chk("to_tout", bus.tout, 1);
    chk("to_rdata", bus.rdata, 8'hFF);
    chk("to_fin_en", bus.en, 0);
    step();
    chk("to_idle_busy", bus.busy, 0);

    // Normal cycle after a timeout clears TOUT.
    bus.req0   = 1'b1;
    bus.val    = 1'b0;
    bus.erdata = 8'h5A;
    step();
    step();
    bus.req0 = 1'b0;
    step();
    chk("nt_done0", bus.done0, 1);
    chk("nt_tout", bus.tout, 0);
    chk("nt_rdata", bus.rdata, 8'h5A);
    bus.val = 1'b1;
    step();

    // VAL falls in the same cycle the watchdog expires: normal completion wins.
    bus.req1  = 1'b1;
    bus.addr1 = 16'h7777;
    step();
    bus.req1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("bd_en", bus.en, 1);
    end
    bus.val    = 1'b0;
    bus.erdata = 8'hC3;
    step();
    chk("bd_done1", bus.done1, 1);
    chk("bd_tout", bus.tout, 0);
    chk("bd_rdata", bus.rdata, 8'hC3);
    bus.val = 1'b1;
    step();

    // Reset in the middle of RUN.
    bus.req0  = 1'b1;
    bus.addr0 = 16'h1234;
    step();
    step();
    step();
    chk("mr_run_en", bus.en, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_en", bus.en, 0);
    chk("mr_brst_n", bus.brst_n, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_address", bus.address, 0);
    chk("mr_done", {bus.done0, bus.done1}, 0);
    step();
    chk("mr_hold_done", {bus.done0, bus.done1}, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("mr_regrant_busy", bus.busy, 1);
    chk("mr_regrant_en", bus.en, 0);
    chk("mr_regrant_addr", bus.address, 16'h1234);
    step();
    chk("mr_regrant_run", bus.en, 1);
    bus.val  = 1'b0;
    bus.req0 = 1'b0;
    step();
    chk("mr_done0", bus.done0, 1);
    step();

    // REQ1 drops during GRANT; REQ0 must wait for IDLE.
    bus.req1  = 1'b1;
    bus.addr1 = 16'hA1A1;
    bus.addr0 = 16'hB0B0;
    step();
    chk("ed_grant_addr", bus.address, 16'hA1A1);
    bus.req1 = 1'b0;
    bus.req0 = 1'b1;
    step();
    chk("ed_run_en", bus.en, 1);
    chk("ed_run_addr", bus.address, 16'hA1A1);
    step();
    chk("ed_done1", bus.done1, 1);
    chk("ed_done0", bus.done0, 0);
    step();
    chk("ed_idle_busy", bus.busy, 0);
    chk("ed_idle_done", {bus.done0, bus.done1}, 0);
    step();
    chk("ed_next_addr", bus.address, 16'hB0B0);
    bus.req0 = 1'b0;
    step();
    step();
    chk("ed_next_done0", bus.done0, 1);
    chk("ed_next_done1", bus.done1, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
